part_74s148_latched_encoder: RTL and testbench

//  8-to-3 priority encoder, the inverse of the 3-to-8 line decoder (74S138-style).

---
 rtl/part_74s148_latched_encoder.sv | 124 ++++++++++++
 tb/tb_part_74s148_latched_encoder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/part_74s148_latched_encoder.sv
// 8-to-3 latched priority encoder with synchronised active-low requests,
// sticky (edge) or level pending bits, valid/ack offer handshake and 74S148 cascade pins.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no offer; waits for ei_n=0 with at least one pending bit
// ST_OFFER | code/valid frozen until ack, regardless of ei_n or new bits
module part_74s148_latched_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ei_n,
    input  logic [7:0] req_n,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic       gs_n,
    output logic       eo_n,
    output logic [7:0] pending
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [SYNC_STAGES-1:0][7:0]  sync_q, sync_d;
    logic [7:0]                   s_dly_q, s_dly_d;
    logic [7:0]                   pending_q, pending_d;
    logic [2:0]                   code_q, code_d;
    logic                         valid_q, valid_d;
    logic                         gs_n_q, gs_n_d;
    logic                         eo_n_q, eo_n_d;

    logic [7:0] s;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;
    logic       accept;

    function automatic logic [2:0] highest_idx(input logic [7:0] v);
        highest_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) highest_idx = 3'(i);
        end
    endfunction

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = req_n;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        s       = sync_q[SYNC_STAGES-1];
        s_dly_d = s;
    end

    // Set and clear may hit the same bit in one cycle; the new edge must win.
    always_comb begin
        accept   = (state_q == ST_OFFER) && ack;
        clr_mask = accept ? (8'h01 << code_q) : 8'h00;
        set_mask = s_dly_q & ~s;
        if (EDGE_MODE) begin
            pending_d = (pending_q & ~clr_mask) | set_mask;
        end else begin
            pending_d = ~s;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (!ei_n && (pending_q != 8'h00)) begin
                    code_d  = highest_idx(pending_q);
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
        gs_n_d = ~valid_d;
        eo_n_d = ~(!ei_n && (pending_d == 8'h00));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sync_q    <= '1;
            s_dly_q   <= 8'hFF;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            gs_n_q    <= 1'b1;
            eo_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            s_dly_q   <= s_dly_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            gs_n_q    <= gs_n_d;
            eo_n_q    <= eo_n_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign gs_n    = gs_n_q;
    assign eo_n    = eo_n_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_part_74s148_latched_encoder.sv
// Bench for the latched priority encoder: directed scenarios on an edge-mode and a
// level-mode instance, then randomized traffic against a cycle-level reference model.
module tb_part_74s148_latched_encoder;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ei_n, ack, ei_n_l, ack_l;
    logic [7:0] req_n, req_n_l;
    logic [2:0] code, code_l;
    logic       valid, gs_n, eo_n, valid_l, gs_n_l, eo_n_l;
    logic [7:0] pending, pending_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    part_74s148_latched_encoder #(.SYNC_STAGES(S), .EDGE_MODE(1'b1)) u_edge (
        .clk(clk), .reset_n(reset_n), .ei_n(ei_n), .req_n(req_n), .ack(ack),
        .code(code), .valid(valid), .gs_n(gs_n), .eo_n(eo_n), .pending(pending)
    );

    part_74s148_latched_encoder #(.SYNC_STAGES(S), .EDGE_MODE(1'b0)) u_level (
        .clk(clk), .reset_n(reset_n), .ei_n(ei_n_l), .req_n(req_n_l), .ack(ack_l),
        .code(code_l), .valid(valid_l), .gs_n(gs_n_l), .eo_n(eo_n_l), .pending(pending_l)
    );

    // Reference model, index 0 = edge-mode instance, 1 = level-mode instance.
    logic [7:0] m_hist [2][S+1];
    logic [7:0] m_pend [2];
    logic [2:0] m_code [2];
    logic       m_valid[2];
    logic       m_eo_n [2];

    function automatic logic [2:0] top_index(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_step();
        logic [7:0] r[2];
        logic       e[2];
        logic       a[2];
        logic [7:0] s, sd, np;
        r[0] = req_n;  e[0] = ei_n;   a[0] = ack;
        r[1] = req_n_l; e[1] = ei_n_l; a[1] = ack_l;
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) begin
                for (int j = 0; j <= S; j++) m_hist[m][j] = 8'hFF;
                m_pend[m]  = 8'h00;
                m_code[m]  = 3'd0;
                m_valid[m] = 1'b0;
                m_eo_n[m]  = 1'b1;
            end else begin
                s  = m_hist[m][S-1];
                sd = m_hist[m][S];
                if (m == 0) begin
                    np = m_pend[m];
                    if (m_valid[m] && a[m]) np[m_code[m]] = 1'b0;
                    np = np | (sd & ~s);
                end else begin
                    np = ~s;
                end
                if (m_valid[m]) begin
                    if (a[m]) m_valid[m] = 1'b0;
                end else if (!e[m] && m_pend[m] != 8'h00) begin
                    m_code[m]  = top_index(m_pend[m]);
                    m_valid[m] = 1'b1;
                end
                m_eo_n[m] = !(!e[m] && np == 8'h00);
                m_pend[m] = np;
                for (int j = S; j > 0; j--) m_hist[m][j] = m_hist[m][j-1];
                m_hist[m][0] = r[m];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_n   = 8'($urandom);
            req_n_l = 8'($urandom);
            tick();
            checks++;
            if ({code, valid, gs_n, eo_n, pending} !== {3'd0, 1'b0, 1'b1, 1'b1, 8'h00}) begin
                failures++;
                $display("FAIL reset_edge got code=%0d valid=%0b gs_n=%0b eo_n=%0b pending=%h exp 0/0/1/1/00",
                         code, valid, gs_n, eo_n, pending);
            end
            checks++;
            if ({code_l, valid_l, gs_n_l, eo_n_l, pending_l} !== {3'd0, 1'b0, 1'b1, 1'b1, 8'h00}) begin
                failures++;
                $display("FAIL reset_level got code=%0d valid=%0b gs_n=%0b eo_n=%0b pending=%h exp 0/0/1/1/00",
                         code_l, valid_l, gs_n_l, eo_n_l, pending_l);
            end
        end
        req_n   = 8'hFF;
        req_n_l = 8'hFF;
        reset_n = 1'b1;
        for (int i = 0; i < S + 2; i++) tick();
    endtask

    task automatic test_latency();
        req_n = 8'hF7;
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++;
            if (valid !== (n == 4)) begin
                failures++;
                $display("FAIL latency_valid edge=k+%0d got=%0b exp=%0b", n - 1, valid, (n == 4));
            end
        end
        checks++;
        if (code !== 3'd3 || gs_n !== 1'b0) begin
            failures++;
            $display("FAIL latency_code got code=%0d gs_n=%0b exp code=3 gs_n=0", code, gs_n);
        end
        req_n = 8'hFF;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        checks++;
        if ({valid, gs_n, eo_n, pending} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL latency_ack got valid=%0b gs_n=%0b eo_n=%0b pending=%h exp 0/1/0/00",
                     valid, gs_n, eo_n, pending);
        end
    endtask

    task automatic test_priority_hold();
        ei_n  = 1'b1;
        req_n = 8'hDB;
        for (int i = 0; i < 4; i++) tick();
        req_n = 8'hFF;
        tick();
        checks++;
        if ({valid, eo_n, pending} !== {1'b0, 1'b1, 8'h24}) begin
            failures++;
            $display("FAIL prio_collect got valid=%0b eo_n=%0b pending=%h exp 0/1/24", valid, eo_n, pending);
        end
        ei_n = 1'b0;
        tick();
        checks++;
        if ({valid, code} !== {1'b1, 3'd5}) begin
            failures++;
            $display("FAIL prio_first got valid=%0b code=%0d exp 1/5", valid, code);
        end
        req_n = 8'h7F;
        for (int i = 0; i < 4; i++) tick();
        req_n = 8'hFF;
        tick();
        checks++;
        if ({valid, code, pending} !== {1'b1, 3'd5, 8'hA4}) begin
            failures++;
            $display("FAIL prio_frozen got valid=%0b code=%0d pending=%h exp 1/5/a4", valid, code, pending);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({valid, pending} !== {1'b0, 8'h84}) begin
            failures++;
            $display("FAIL prio_gap got valid=%0b pending=%h exp 0/84", valid, pending);
        end
        tick();
        checks++;
        if ({valid, code} !== {1'b1, 3'd7}) begin
            failures++;
            $display("FAIL prio_second got valid=%0b code=%0d exp 1/7", valid, code);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++;
        if ({valid, code} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL prio_third got valid=%0b code=%0d exp 1/2", valid, code);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({valid, pending} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL prio_drain got valid=%0b pending=%h exp 0/00", valid, pending);
        end
    endtask

    task automatic test_collision();
        req_n = 8'hEF;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({valid, code} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL coll_offer got valid=%0b code=%0d exp 1/4", valid, code);
        end
        req_n = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        req_n = 8'hEF;
        tick();
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({valid, pending} !== {1'b0, 8'h10}) begin
            failures++;
            $display("FAIL coll_set_wins got valid=%0b pending=%h exp 0/10", valid, pending);
        end
        tick();
        checks++;
        if ({valid, code} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL coll_reoffer got valid=%0b code=%0d exp 1/4", valid, code);
        end
        req_n = 8'hFF;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        checks++;
        if ({valid, pending} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL coll_clear got valid=%0b pending=%h exp 0/00", valid, pending);
        end
    endtask

    task automatic test_cascade();
        ei_n  = 1'b1;
        req_n = 8'hFE;
        for (int i = 0; i < 4; i++) tick();
        req_n = 8'hFF;
        tick();
        checks++;
        if ({valid, eo_n, pending} !== {1'b0, 1'b1, 8'h01}) begin
            failures++;
            $display("FAIL casc_blocked got valid=%0b eo_n=%0b pending=%h exp 0/1/01", valid, eo_n, pending);
        end
        ei_n = 1'b0;
        tick();
        checks++;
        if ({valid, code, eo_n} !== {1'b1, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL casc_offer got valid=%0b code=%0d eo_n=%0b exp 1/0/1", valid, code, eo_n);
        end
        ei_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({valid, code} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL casc_hold got valid=%0b code=%0d exp 1/0", valid, code);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({valid, eo_n, pending} !== {1'b0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL casc_ack got valid=%0b eo_n=%0b pending=%h exp 0/1/00", valid, eo_n, pending);
        end
        ei_n = 1'b0;
        tick();
        checks++;
        if ({valid, eo_n} !== {1'b0, 1'b0}) begin
            failures++;
            $display("FAIL casc_eo got valid=%0b eo_n=%0b exp 0/0", valid, eo_n);
        end
    endtask

    task automatic test_level();
        req_n_l = 8'hBF;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({valid_l, code_l} !== {1'b1, 3'd6}) begin
            failures++;
            $display("FAIL level_offer got valid=%0b code=%0d exp 1/6", valid_l, code_l);
        end
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        checks++;
        if ({valid_l, pending_l} !== {1'b0, 8'h40}) begin
            failures++;
            $display("FAIL level_gap got valid=%0b pending=%h exp 0/40", valid_l, pending_l);
        end
        tick();
        checks++;
        if ({valid_l, code_l} !== {1'b1, 3'd6}) begin
            failures++;
            $display("FAIL level_reoffer got valid=%0b code=%0d exp 1/6", valid_l, code_l);
        end
        req_n_l = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({valid_l, pending_l} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL level_release got valid=%0b pending=%h exp 1/00", valid_l, pending_l);
        end
        ack_l = 1'b1;
        tick();
        ack_l = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({valid_l, eo_n_l, pending_l} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL level_idle got valid=%0b eo_n=%0b pending=%h exp 0/0/00", valid_l, eo_n_l, pending_l);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(1, 0) == 1) req_n = 8'($urandom);
            if ($urandom_range(1, 0) == 1) req_n_l = 8'($urandom);
            ei_n    = ($urandom_range(9, 0) < 2);
            ei_n_l  = ($urandom_range(9, 0) < 2);
            ack     = ($urandom_range(9, 0) < 4);
            ack_l   = ($urandom_range(9, 0) < 4);
            reset_n = (c != 300);
            tick();
            checks++;
            if ({code, valid, gs_n, eo_n, pending} !==
                {m_code[0], m_valid[0], ~m_valid[0], m_eo_n[0], m_pend[0]}) begin
                failures++;
                $display("FAIL rand_edge cyc=%0d got code=%0d valid=%0b gs_n=%0b eo_n=%0b pend=%h exp code=%0d valid=%0b gs_n=%0b eo_n=%0b pend=%h",
                         c, code, valid, gs_n, eo_n, pending,
                         m_code[0], m_valid[0], ~m_valid[0], m_eo_n[0], m_pend[0]);
            end
            checks++;
            if ({code_l, valid_l, gs_n_l, eo_n_l, pending_l} !==
                {m_code[1], m_valid[1], ~m_valid[1], m_eo_n[1], m_pend[1]}) begin
                failures++;
                $display("FAIL rand_level cyc=%0d got code=%0d valid=%0b gs_n=%0b eo_n=%0b pend=%h exp code=%0d valid=%0b gs_n=%0b eo_n=%0b pend=%h",
                         c, code_l, valid_l, gs_n_l, eo_n_l, pending_l,
                         m_code[1], m_valid[1], ~m_valid[1], m_eo_n[1], m_pend[1]);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        ei_n    = 1'b0;
        ei_n_l  = 1'b0;
        ack     = 1'b0;
        ack_l   = 1'b0;
        req_n   = 8'hFF;
        req_n_l = 8'hFF;
        #2;
        test_reset();
        test_latency();
        test_priority_hold();
        test_collision();
        test_cascade();
        test_level();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
